hazard_controller: RTL

Pipeline sequencing controller for the 5-stage core. It generates latch enables and NOP-insert controls for PC, F/D, D/X and X/M, and detects load-use hazards that forwarding cannot cover. It flushes wrong-path instructions on a taken branch or jump and runs the start/wait/release handshake with the multi-cycle multdiv unit. It sits beside the forwarding logic, reads the D- and X-stage instruction registers, and drives every pipeline-latch control.

---
 rtl/isa_defs.sv | 31 +++
 rtl/load_use_detect.sv | 50 +++++
 rtl/hazard_controller.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/isa_defs.sv
`default_nettype none
// ============================================================================
// Module   : isa_defs
// Brief    : Instruction field positions, opcode/aluop constants and the
//            hazard-controller FSM encoding for the 5-stage core.
// Revision : 1.0
// ============================================================================
package isa_defs;

    localparam int c_fld_w   = 5;
    localparam int c_op_lsb  = 27;
    localparam int c_rd_lsb  = 22;
    localparam int c_rs_lsb  = 17;
    localparam int c_rt_lsb  = 12;
    localparam int c_alu_lsb = 2;

    localparam logic [4:0] c_op_rtype = 5'b00000;
    localparam logic [4:0] c_op_lw    = 5'b01000;
    localparam logic [4:0] c_op_sw    = 5'b00111;
    localparam logic [4:0] c_op_bne   = 5'b00010;
    localparam logic [4:0] c_op_blt   = 5'b00110;
    localparam logic [4:0] c_op_jr    = 5'b00100;

    localparam logic [4:0] c_alu_mul  = 5'b00110;
    localparam logic [4:0] c_alu_div  = 5'b00111;

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_busy  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : load_use_detect
// Brief    : Flags a D-stage instruction that reads the destination of a
//            non-r0 load currently in X (forwarding cannot cover it).
// Revision : 1.0
// ============================================================================
module load_use_detect
    import isa_defs::*;
(
    input  logic [31:0] i_ir_d,
    input  logic [31:0] i_ir_x,
    output logic        o_hazard
);

    logic [4:0] w_op_d;
    logic [4:0] w_rd_d;
    logic [4:0] w_rs_d;
    logic [4:0] w_rt_d;
    logic [4:0] w_op_x;
    logic [4:0] w_rd_x;
    logic       w_x_is_load;
    logic       w_reads_rt;
    logic       w_reads_rd;
    logic       w_unused;

    assign w_op_d = i_ir_d[c_op_lsb +: c_fld_w];
    assign w_rd_d = i_ir_d[c_rd_lsb +: c_fld_w];
    assign w_rs_d = i_ir_d[c_rs_lsb +: c_fld_w];
    assign w_rt_d = i_ir_d[c_rt_lsb +: c_fld_w];
    assign w_op_x = i_ir_x[c_op_lsb +: c_fld_w];
    assign w_rd_x = i_ir_x[c_rd_lsb +: c_fld_w];

    assign w_unused = ^{i_ir_d[11:0], i_ir_x[21:0]};

    // r0 is hardwired, so a load into it never creates a dependency
    assign w_x_is_load = (w_op_x == c_op_lw) && (w_rd_x != 5'd0);

    // Stores, compare-branches and jr read the rd field as a source
    assign w_reads_rt = (w_op_d == c_op_rtype);
    assign w_reads_rd = (w_op_d == c_op_sw)  || (w_op_d == c_op_bne) ||
                        (w_op_d == c_op_blt) || (w_op_d == c_op_jr);

    assign o_hazard = w_x_is_load &&
                      ((w_rs_d == w_rd_x) ||
                       (w_reads_rt && (w_rt_d == w_rd_x)) ||
                       (w_reads_rd && (w_rd_d == w_rd_x)));

endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_controller
// Brief    : Pipeline latch enables / nop inserts, load-use stall, branch
//            flush and the multdiv start/wait/release handshake.
// Revision : 1.0
// ============================================================================
module hazard_controller
    import isa_defs::*;
#(
    parameter int MD_TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR_D,
    input  logic [31:0] IR_X,
    input  logic        branch_taken,
    input  logic        md_ready,
    output logic        pc_en,
    output logic        fd_en,
    output logic        dx_en,
    output logic        xm_en,
    output logic        fd_nop,
    output logic        dx_nop,
    output logic        xm_nop,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        md_result_sel,
    output logic        md_timeout,
    output logic [31:0] stall_count
);

    localparam logic [5:0] c_cnt_last = 6'(MD_TIMEOUT - 1);

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic [5:0]  r_cnt;
    logic        r_md_timeout;
    logic [31:0] r_stall_count;
    logic        w_load_use;
    logic        w_x_is_mul;
    logic        w_x_is_div;
    logic        w_cnt_done;
    logic        w_unused;

    load_use_detect u_load_use_detect (
        .i_ir_d   (IR_D),
        .i_ir_x   (IR_X),
        .o_hazard (w_load_use)
    );

    assign w_x_is_mul = (IR_X[c_op_lsb +: c_fld_w] == c_op_rtype) &&
                        (IR_X[c_alu_lsb +: c_fld_w] == c_alu_mul);
    assign w_x_is_div = (IR_X[c_op_lsb +: c_fld_w] == c_op_rtype) &&
                        (IR_X[c_alu_lsb +: c_fld_w] == c_alu_div);
    assign w_cnt_done = (r_cnt == c_cnt_last);
    assign w_unused   = ^{IR_X[26:7], IR_X[1:0]};

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (w_x_is_mul || w_x_is_div) w_state_next = c_st_busy;
            c_st_busy: if (md_ready || w_cnt_done)   w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    // Output logic: FSM stall outranks flush, which outranks load-use
    always_comb begin
        pc_en         = 1'b1;
        fd_en         = 1'b1;
        dx_en         = 1'b1;
        xm_en         = 1'b1;
        fd_nop        = 1'b0;
        dx_nop        = 1'b0;
        xm_nop        = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        md_result_sel = 1'b0;
        if (!reset) begin
            fd_nop = 1'b1;
            dx_nop = 1'b1;
            xm_nop = 1'b1;
        end else if (r_state == c_st_busy) begin
            if (md_ready) begin
                md_result_sel = 1'b1;
            end else if (w_cnt_done) begin
                xm_nop = 1'b1;
            end else begin
                pc_en  = 1'b0;
                fd_en  = 1'b0;
                dx_en  = 1'b0;
                xm_nop = 1'b1;
            end
        end else if (w_x_is_mul || w_x_is_div) begin
            ctrl_MULT = w_x_is_mul;
            ctrl_DIV  = w_x_is_div;
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_en     = 1'b0;
            xm_nop    = 1'b1;
        end else if (branch_taken) begin
            fd_nop = 1'b1;
            dx_nop = 1'b1;
        end else if (w_load_use) begin
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            dx_nop = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt         <= 6'd0;
            r_md_timeout  <= 1'b0;
            r_stall_count <= 32'd0;
        end else begin
            if (r_state == c_st_idle) begin
                r_cnt <= 6'd0;
            end else if (!md_ready && !w_cnt_done) begin
                r_cnt <= r_cnt + 6'd1;
            end
            if ((r_state == c_st_busy) && !md_ready && w_cnt_done) begin
                r_md_timeout <= 1'b1;
            end
            if (!pc_en && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign md_timeout  = r_md_timeout;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire
